// File: rtl/if_fetch_unit.sv
// ---------------------------------------------------------------------------
// if_fetch_unit
//
// PC generator and IF/ID pipeline register for the 5-stage RV32 core.
//
// The instruction memory is synchronous with a one-cycle registered read.
// The word on imem_rdata_i therefore always belongs to the address that was
// driven in the previous cycle. This block remembers that address
// (resp_pc_q) and whether it is a real fetch (resp_valid_q). It pairs the
// returned word with its PC and presents the pair to the ID stage.
//
// Optional feature macro: IF_FAULT_EN
//   When defined, the fetch_fault_o port is present. It is a registered
//   one-cycle pulse that follows a redirect whose target is not word aligned.
//   Fetch always continues from the word-aligned address. When the macro is
//   undefined, the port is absent and the low target bits are dropped
//   silently.
//
// Parameters:
//   RESET_PC       first fetch address after reset
//   NOP_INSTR      word presented on ifid_instr_o while IF/ID holds a bubble
//
// Ports:
//   clk            clock
//   reset          synchronous, active-high reset
//   stall_i        hold IF and IF/ID (hazard unit)
//   redirect_i     flush and refetch from redirect_pc_i (EX stage);
//                  takes priority over stall_i
//   redirect_pc_i  redirect target byte address
//   imem_addr_o    byte address to instruction memory
//   imem_rdata_i   word for the address driven in the previous cycle
//   ifid_valid_o   IF/ID holds a real instruction
//   ifid_pc_o      PC of ifid_instr_o
//   ifid_pc4_o     ifid_pc_o + 4 (mod 2^32)
//   ifid_instr_o   fetched instruction, NOP_INSTR when invalid
//   fetch_fault_o  misaligned redirect pulse (IF_FAULT_EN only)
// ---------------------------------------------------------------------------
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic [31:0] imem_addr_o,
  input  logic [31:0] imem_rdata_i,
  output logic        ifid_valid_o,
  output logic [31:0] ifid_pc_o,
  output logic [31:0] ifid_pc4_o,
  output logic [31:0] ifid_instr_o
`ifdef IF_FAULT_EN
  ,
  output logic        fetch_fault_o
`endif
);

  // Fetch-side state.
  logic [31:0] pc_q;          // next address to issue
  logic [31:0] resp_pc_q;     // address whose data arrives this cycle
  logic        resp_valid_q;  // that data belongs to a real fetch

  // IF/ID pipeline register.
  logic        ifid_valid_q;
  logic [31:0] ifid_pc_q;
  logic [31:0] ifid_instr_q;

  logic [31:0] redirect_pc_aligned;
  logic        hold;

  assign redirect_pc_aligned = {redirect_pc_i[31:2], 2'b00};

  // A redirect always wins over a stall, so only a stall without a
  // redirect freezes the pipeline.
  assign hold = stall_i && !redirect_i;

  // During a stall, the pending address is issued again. Then the memory
  // output in the cycle after the stall is still the word for resp_pc_q,
  // and nothing is skipped or duplicated. In reset, RESET_PC is driven so
  // that the memory sees a sane address.
  always_comb begin
    imem_addr_o = pc_q;
    if (reset) begin
      imem_addr_o = RESET_PC;
    end else if (hold) begin
      imem_addr_o = resp_pc_q;
    end
  end

  // Fetch state and IF/ID register. Reset discards any in-flight read and
  // any pending stall or redirect. A redirect drops the in-flight read by
  // clearing resp_valid_q. This gives two bubbles before the target
  // reaches IF/ID.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q         <= RESET_PC;
      resp_pc_q    <= 32'h0000_0000;
      resp_valid_q <= 1'b0;
      ifid_valid_q <= 1'b0;
      ifid_pc_q    <= 32'h0000_0000;
      ifid_instr_q <= NOP_INSTR;
    end else if (redirect_i) begin
      pc_q         <= redirect_pc_aligned;
      resp_valid_q <= 1'b0;
      ifid_valid_q <= 1'b0;
      ifid_instr_q <= NOP_INSTR;
    end else if (!stall_i) begin
      ifid_valid_q <= resp_valid_q;
      ifid_pc_q    <= resp_pc_q;
      ifid_instr_q <= resp_valid_q ? imem_rdata_i : NOP_INSTR;
      resp_pc_q    <= pc_q;
      resp_valid_q <= 1'b1;
      pc_q         <= pc_q + 32'd4;
    end
  end

  assign ifid_valid_o = ifid_valid_q;
  assign ifid_pc_o    = ifid_pc_q;
  assign ifid_pc4_o   = ifid_pc_q + 32'd4;
  assign ifid_instr_o = ifid_instr_q;

`ifdef IF_FAULT_EN
  logic fault_q;

  // The fault pulse lasts exactly one cycle. It is raised in the cycle
  // after a redirect whose target has nonzero low bits.
  always_ff @(posedge clk) begin
    if (reset) begin
      fault_q <= 1'b0;
    end else begin
      fault_q <= redirect_i && (redirect_pc_i[1:0] != 2'b00);
    end
  end

  assign fetch_fault_o = fault_q;
`else
  // The low target bits are intentionally ignored in this build.
  logic unused_redirect_lowbits;
  assign unused_redirect_lowbits = ^redirect_pc_i[1:0];
`endif

endmodule
